// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default widths, bit-clock divider and the sample type
// used by both the player and the I2S transmitter.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;
  localparam int AUDIO_SLOT_W   = 16;
  localparam int AUDIO_BCLK_DIV = 2;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: divides clk down to bclk and strobes the cycle in which
// bclk is about to fall, so downstream logic can update on the falling edge.
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall_evt
);

  localparam int                DIV_W    = cnt_w(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             bclk_reg;
  logic             wrap;

  assign wrap         = (div_cnt_reg == DIV_LAST);
  assign div_cnt_next = wrap ? '0 : div_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      if (wrap) begin
        bclk_reg <= ~bclk_reg;
      end
    end
  end

  assign bclk     = bclk_reg;
  assign fall_evt = wrap & bclk_reg;

endmodule

// File: rtl/i2s_frame_tx.sv
// Stereo I2S transmitter: sends one mono sample in both slots and pulses new_frame per frame.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified output (no one-bclk data delay).
module i2s_frame_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = AUDIO_BCLK_DIV,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W   = AUDIO_SLOT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                new_frame,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int               FRAME_W  = 2 * SLOT_W;
  localparam int               CNT_W    = cnt_w(FRAME_W);
  localparam int               PAD_W    = SLOT_W - SAMPLE_W;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RIGHT_0  = CNT_W'(SLOT_W);

  logic               fall_evt;
  logic               boundary;
  logic [SLOT_W-1:0]  word;
  logic [FRAME_W-1:0] frame_word;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic [FRAME_W-1:0] shift_reg;
  logic               lrclk_reg;
  logic               sdata_reg;
  logic               new_frame_reg;

  audio_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  // Sample left-aligned in the slot; padding LSBs and muted frames are zero.
  for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_word
    if (gi >= PAD_W) begin : g_data
      assign word[gi] = play & sample_in[gi-PAD_W];
    end else begin : g_pad
      assign word[gi] = 1'b0;
    end
  end

  assign frame_word   = {word, word};
  assign boundary     = fall_evt && (bit_cnt_reg == BIT_LAST);
  assign bit_cnt_next = boundary ? '0 : bit_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      lrclk_reg     <= 1'b0;
      sdata_reg     <= 1'b0;
      new_frame_reg <= 1'b0;
    end else begin
      new_frame_reg <= boundary;
      if (fall_evt) begin
        bit_cnt_reg <= bit_cnt_next;
        lrclk_reg   <= (bit_cnt_next >= RIGHT_0);
        if (boundary) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
          shift_reg <= frame_word << 1;
          sdata_reg <= frame_word[FRAME_W-1];
`else
          // After 2*SLOT_W-1 shifts the MSB holds the old right-slot LSB, which
          // acts as the one-bclk delay bit for the new frame's first slot.
          shift_reg <= frame_word;
          sdata_reg <= shift_reg[FRAME_W-1];
`endif
        end else begin
          shift_reg <= shift_reg << 1;
          sdata_reg <= shift_reg[FRAME_W-1];
        end
      end
    end
  end

  assign lrclk     = lrclk_reg;
  assign sdata     = sdata_reg;
  assign new_frame = new_frame_reg;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: frame-level vector table, per-cycle reference model,
// random play/sample activity and reset corner sequences.
module tb_i2s_frame_tx;
  import audio_pkg::*;

  localparam int B     = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 2 * SLOT;
  localparam int NVEC  = 9;

  logic    clk;
  logic    reset;
  logic    play;
  sample_t sample_in;
  logic    new_frame;
  logic    bclk;
  logic    lrclk;
  logic    sdata;

  int errors = 0;
  int checks = 0;

  i2s_frame_tx #(
    .BCLK_DIV (B),
    .SAMPLE_W (16),
    .SLOT_W   (SLOT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .sample_in (sample_in),
    .new_frame (new_frame),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: everything derived from the number of clk edges since reset.
  int          m_n;
  int          m_f;
  int          m_k;
  int          m_fr;
  logic [15:0] words_q[$];
  logic        exp_bclk;
  logic        exp_lr;
  logic        exp_sd;
  logic        exp_nf;

  function automatic logic model_bit(input int k, input int fr);
    logic [15:0] w;
    w = words_q[fr];
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return (k < SLOT) ? w[SLOT-1-k] : w[FRAME-1-k];
`else
    if (k == 0) begin
      logic [15:0] p;
      p = (fr > 0) ? words_q[fr-1] : 16'h0;
      return p[0];
    end
    return (k <= SLOT) ? w[SLOT-k] : w[FRAME-k];
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_n = 0;
      words_q = {};
      words_q.push_back(16'h0);
      exp_bclk = 1'b0;
      exp_lr   = 1'b0;
      exp_sd   = 1'b0;
      exp_nf   = 1'b0;
    end else begin
      m_n  = m_n + 1;
      m_f  = m_n / (2 * B);
      m_k  = m_f % FRAME;
      m_fr = m_f / FRAME;
      exp_nf = (m_n % (2 * B) == 0) && (m_f > 0) && (m_k == 0);
      if (exp_nf) words_q.push_back(play ? sample_in : 16'h0);
      exp_bclk = ((m_n / B) % 2) == 1;
      exp_lr   = (m_k >= SLOT);
      exp_sd   = model_bit(m_k, m_fr);
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({bclk, lrclk, sdata, new_frame} !== {exp_bclk, exp_lr, exp_sd, exp_nf}) begin
      errors++;
      $display("FAIL model t=%0t {bclk,lrclk,sdata,new_frame} got=%b exp=%b",
               $time, {bclk, lrclk, sdata, new_frame}, {exp_bclk, exp_lr, exp_sd, exp_nf});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        play;
    logic [15:0] sample;
    logic [15:0] exp_word;
    int          drive_at;  // bit of the previous frame at which inputs change
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    play      = v.play;
    sample_in = v.sample;
  endtask

  task automatic next_rise(output logic b, output logic lr);
    logic last;
    bit   got;
    got  = 0;
    b    = 1'b0;
    lr   = 1'b0;
    last = bclk;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (bclk === 1'b1 && last === 1'b0) begin
        got = 1;
        b   = sdata;
        lr  = lrclk;
      end
      last = bclk;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bclk_rise timeout");
    end
  endtask

  task automatic count_to_nf(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (new_frame === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  initial begin
    logic [32:0] r;
    logic [32:0] lr;
    logic [15:0] left;
    logic [15:0] right;
    logic [31:0] lr_bits;
    int          cyc;

    vecs[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 31};
    vecs[1] = '{1'b1, 16'hA5C3, 16'hA5C3, 31};
    vecs[2] = '{1'b0, 16'hA5C3, 16'h0000, 8};
    vecs[3] = '{1'b1, 16'h7FFF, 16'h7FFF, 8};
    vecs[4] = '{1'b1, 16'h1234, 16'h1234, 31};
    vecs[5] = '{1'b1, 16'h8001, 16'h8001, 0};
    vecs[6] = '{1'b1, 16'h0001, 16'h0001, 31};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0000, 31};
    vecs[8] = '{1'b1, 16'h8000, 16'h8000, 31};

    reset = 1'b1;
    play = 1'b0;
    sample_in = '0;
    #2 reset = 1'b0;
    #1 check("reset_outputs", {28'h0, bclk, lrclk, sdata, new_frame}, 32'h0);
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // First pulse: 32 bclk periods after release, then one clk wide.
    count_to_nf(cyc);
    check("first_nf_delay", 32'(cyc), 32'(FRAME * 2 * B));
    @(negedge clk);
    check("nf_width", {31'h0, new_frame}, 32'h0);

    next_rise(r[0], lr[0]);
    for (int i = 0; i < NVEC; i++) begin
      if (i + 1 < NVEC && vecs[i+1].drive_at == 0) drive(vecs[i+1]);
      for (int j = 1; j <= 32; j++) begin
        next_rise(r[j], lr[j]);
        if (j < 32 && i + 1 < NVEC && vecs[i+1].drive_at == j) drive(vecs[i+1]);
      end
      left  = '0;
      right = '0;
      for (int j = 0; j < SLOT; j++) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        left  = {left[14:0], r[j]};
        right = {right[14:0], r[SLOT+j]};
`else
        left  = {left[14:0], r[1+j]};
        right = {right[14:0], r[SLOT+1+j]};
`endif
      end
      for (int j = 0; j < FRAME; j++) lr_bits[j] = lr[j];
      $display("vec %0d play=%b sample=%h left=%h right=%h", i, vecs[i].play,
               vecs[i].sample, left, right);
      check($sformatf("vec%0d_left", i), {16'h0, left}, {16'h0, vecs[i].exp_word});
      check($sformatf("vec%0d_right", i), {16'h0, right}, {16'h0, vecs[i].exp_word});
      check($sformatf("vec%0d_lrclk", i), lr_bits, 32'hFFFF_0000);
      r[0]  = r[32];
      lr[0] = lr[32];
    end

    // Random play/sample activity at arbitrary cycles; the per-cycle model judges it.
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) sample_in = sample_t'($urandom);
      if ($urandom_range(0, 63) == 0) play = ~play;
    end

    // Reset at bit 20: outputs clear at once, frame timing restarts.
    count_to_nf(cyc);
    for (int j = 0; j <= 20; j++) next_rise(r[0], lr[0]);
    #2 reset = 1'b0;
    #1 check("midframe_reset_outputs", {28'h0, bclk, lrclk, sdata, new_frame}, 32'h0);
    play = 1'b1;
    sample_in = 16'h5A3C;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    count_to_nf(cyc);
    check("post_reset_nf_delay", 32'(cyc), 32'(FRAME * 2 * B));
    count_to_nf(cyc);
    check("nf_period", 32'(cyc), 32'(FRAME * 2 * B));
    repeat (2 * FRAME * 2 * B) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
